// File: rtl/addressable_register_bank_pkg.sv
// ============================================================================
// addressable_register_bank_pkg
// Shared types and helpers for the addressable register bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

package addressable_register_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_MISS   = 2'd2
  } state_e;

  // A single-register bank still needs one pointer bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addressable_register_bank_decoder.sv
// ============================================================================
// reg_bank_decoder
// Range check of a start address against the bank, plus base subtraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_bank_decoder #(
  parameter int AddressWidth = 8,
  parameter int BaseAddress  = 'h00,
  parameter int Depth        = 8,
  parameter int PtrWidth     = 3
) (
  input  logic [AddressWidth-1:0] addr,
  output logic                    in_range,
  output logic [PtrWidth-1:0]     ptr_load
);

  localparam logic [AddressWidth:0] c_base  = (AddressWidth+1)'(BaseAddress);
  localparam logic [AddressWidth:0] c_depth = (AddressWidth+1)'(Depth);

  // One extra bit keeps the borrow: an address below the base wraps to a
  // huge offset and fails the single upper-bound compare.
  logic [AddressWidth:0] w_offset;

  always_comb begin
    w_offset = {1'b0, addr} - c_base;
    in_range = (w_offset < c_depth);
    ptr_load = w_offset[PtrWidth-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/addressable_register_bank.sv
// ============================================================================
// addressable_register_bank
// Depth registers with auto-incrementing pointer, registered read-back and a
// write-only mask. Define REG_BANK_SHADOW_EN for shadow/commit buffering.
// Revision: 1.0
// ============================================================================
`default_nettype none

module addressable_register_bank
  import addressable_register_bank_pkg::*;
#(
  parameter int               AddressWidth  = 8,
  parameter int               BaseAddress   = 'h00,
  parameter int               BitWidth      = 8,
  parameter int               Depth         = 8,
  parameter logic [Depth-1:0] WriteOnlyMask = '0
) (
  input  logic                      CLK,
  input  logic                      _RST,
  input  logic                      Start,
  input  logic [AddressWidth-1:0]   AddressBus,
  input  logic                      WriteStrobe,
  input  logic                      ReadStrobe,
  input  logic [BitWidth-1:0]       DataIn,
  input  logic                      Commit,
  output logic [BitWidth-1:0]       DataOut,
  output logic                      DataValid,
  output logic                      Hit,
  output logic                      Pending,
  output logic [Depth*BitWidth-1:0] Regs
);

  localparam int PtrWidth = ptr_width(Depth);

  state_e                state_q, state_d, cur_state;
  logic [PtrWidth-1:0]   ptr_q, ptr_d, cur_ptr, ptr_load;
  logic                  in_range;
  logic [BitWidth-1:0]   regs_q [Depth];
  logic [BitWidth-1:0]   regs_d [Depth];
  logic [BitWidth-1:0]   data_out_q, data_out_d, rd_word;
  logic                  data_valid_q, data_valid_d;
  logic                  hit_q, hit_d;
  logic                  wr_en, rd_en;

  reg_bank_decoder #(
    .AddressWidth (AddressWidth),
    .BaseAddress  (BaseAddress),
    .Depth        (Depth),
    .PtrWidth     (PtrWidth)
  ) u_decoder (
    .addr     (AddressBus),
    .in_range (in_range),
    .ptr_load (ptr_load)
  );

  // A strobe coincident with Start acts on the freshly decoded pointer.
  always_comb begin
    cur_state = state_q;
    cur_ptr   = ptr_q;
    if (Start) begin
      cur_state = in_range ? ST_ACTIVE : ST_MISS;
      if (in_range) cur_ptr = ptr_load;
    end
    wr_en = WriteStrobe && (cur_state == ST_ACTIVE);
    rd_en = ReadStrobe && (cur_state != ST_IDLE);
  end

`ifdef REG_BANK_SHADOW_EN
  logic [BitWidth-1:0] shadow_q [Depth];
  logic [BitWidth-1:0] shadow_d [Depth];
  logic                pending_q, pending_d;

  always_comb begin
    shadow_d  = shadow_q;
    regs_d    = Commit ? shadow_q : regs_q;
    pending_d = Commit ? 1'b0 : pending_q;
    if (wr_en) begin
      shadow_d[cur_ptr] = DataIn;
      pending_d         = 1'b1;
    end
    rd_word = shadow_q[cur_ptr];
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      for (int k = 0; k < Depth; k++) shadow_q[k] <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign Pending = pending_q;
`else
  logic unused_commit;
  assign unused_commit = Commit;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[cur_ptr] = DataIn;
    rd_word = regs_q[cur_ptr];
  end

  assign Pending = 1'b0;
`endif

  always_comb begin
    state_d      = cur_state;
    ptr_d        = cur_ptr;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (rd_en) begin
      data_valid_d = 1'b1;
      data_out_d   = ((cur_state == ST_ACTIVE) && !WriteOnlyMask[cur_ptr]) ? rd_word : '0;
    end
    if ((cur_state == ST_ACTIVE) && (WriteStrobe || ReadStrobe)) begin
      ptr_d = (cur_ptr == PtrWidth'(Depth - 1)) ? '0 : cur_ptr + PtrWidth'(1);
    end
    hit_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      for (int k = 0; k < Depth; k++) regs_q[k] <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      regs_q       <= regs_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      hit_q        <= hit_d;
    end
  end

  generate
    for (genvar k = 0; k < Depth; k++) begin : g_regs
      assign Regs[k*BitWidth +: BitWidth] = regs_q[k];
    end
  endgenerate

  assign DataOut   = data_out_q;
  assign DataValid = data_valid_q;
  assign Hit       = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_addressable_register_bank.sv
// ============================================================================
// tb_addressable_register_bank
// Directed checks of the register bank (Depth=8, base 'h10, reg2 write-only).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_addressable_register_bank;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  addr;
  logic        we;
  logic        re;
  logic [7:0]  din;
  logic        commit;
  logic [7:0]  dout;
  logic        dvalid;
  logic        hit;
  logic        pending;
  logic [63:0] regs;

  int n_checks = 0;
  int n_errors = 0;

  addressable_register_bank #(
    .AddressWidth  (8),
    .BaseAddress   ('h10),
    .BitWidth      (8),
    .Depth         (8),
    .WriteOnlyMask (8'b0000_0100)
  ) dut (
    .CLK         (clk),
    ._RST        (rst_n),
    .Start       (start),
    .AddressBus  (addr),
    .WriteStrobe (we),
    .ReadStrobe  (re),
    .DataIn      (din),
    .Commit      (commit),
    .DataOut     (dout),
    .DataValid   (dvalid),
    .Hit         (hit),
    .Pending     (pending),
    .Regs        (regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, release inputs.
  task automatic step(input logic s, input logic [7:0] a, input logic w,
                      input logic r, input logic [7:0] d, input logic c);
    start = s; addr = a; we = w; re = r; din = d; commit = c;
    @(posedge clk);
    #1;
    start = 0; we = 0; re = 0; commit = 0;
  endtask

  // Make pending shadow contents visible on Regs when buffering is built in.
  task automatic publish();
`ifdef REG_BANK_SHADOW_EN
    step(0, 8'h00, 0, 0, 8'h00, 1);
`endif
  endtask

  initial begin
    rst_n = 0; start = 0; addr = 0; we = 0; re = 0; din = 0; commit = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs",    regs,    64'h0);
    check("reset_hit",     hit,     0);
    check("reset_valid",   dvalid,  0);
    check("reset_dout",    dout,    0);
    check("reset_pending", pending, 0);
    @(negedge clk);
    rst_n = 1;
    #1;

    // IDLE ignores strobes
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("idle_read_valid", dvalid, 0);
    check("idle_hit",        hit,    0);
    step(0, 8'h00, 1, 0, 8'hEE, 0);
    publish();
    check("idle_write_regs", regs, 64'h0);

    // Start at 'h16 with write, wrap past reg7
    step(1, 8'h16, 1, 0, 8'hA1, 0);
    check("wr_a1_hit", hit, 1);
    step(0, 8'h00, 1, 0, 8'hA2, 0);
    check("wr_a2_hit", hit, 1);
    step(0, 8'h00, 1, 0, 8'hA3, 0);
    check("wr_a3_hit", hit, 1);
`ifndef REG_BANK_SHADOW_EN
    check("wr_direct_regs", regs, 64'hA2A1_0000_0000_00A3);
    check("nosh_pending",   pending, 0);
`endif
    publish();
    check("wrap_regs", regs, 64'hA2A1_0000_0000_00A3);

    // Read back with wrap
    step(1, 8'h16, 0, 1, 8'h00, 0);
    check("rd6_data",  dout,   8'hA1);
    check("rd6_valid", dvalid, 1);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("rd7_data", dout, 8'hA2);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("rd0_data", dout, 8'hA3);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    check("valid_pulse_end", dvalid, 0);

    // Range boundaries
    step(1, 8'h17, 0, 0, 8'h00, 0);
    check("addr17_hit", hit, 1);
    step(1, 8'h18, 0, 0, 8'h00, 0);
    check("addr18_miss", hit, 0);
    step(1, 8'h0F, 0, 0, 8'h00, 0);
    check("addr0f_miss", hit, 0);

    // Miss: writes ignored, reads give zero with valid
    step(1, 8'h20, 1, 0, 8'h55, 0);
    check("miss_hit", hit, 0);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("miss_dout",  dout,   8'h00);
    check("miss_valid", dvalid, 1);
    check("miss_hit2",  hit,    0);
    publish();
    check("miss_regs", regs, 64'hA2A1_0000_0000_00A3);

    // Write-only register 2
    step(1, 8'h12, 1, 0, 8'h3C, 0);
    step(0, 8'h00, 1, 0, 8'h33, 0);
    step(1, 8'h11, 1, 0, 8'h11, 0);
    publish();
    check("mask_regs", regs, 64'hA2A1_0000_333C_11A3);
    step(1, 8'h12, 0, 1, 8'h00, 0);
    check("mask_dout",  dout,   8'h00);
    check("mask_valid", dvalid, 1);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("rd3_data", dout, 8'h33);

    // Same-cycle read and write of reg1, pointer advances by one
    step(1, 8'h11, 1, 1, 8'h22, 0);
    check("rw_old_data", dout,   8'h11);
    check("rw_valid",    dvalid, 1);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("rw_next_ptr", dout, 8'h00);
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("rw_next_ptr2", dout, 8'h33);
    publish();
    check("rw_regs", regs, 64'hA2A1_0000_333C_22A3);

    // Asynchronous reset mid-transaction
    step(1, 8'h14, 1, 0, 8'h99, 0);
    rst_n = 0;
    #1;
    check("async_rst_regs", regs, 64'h0);
    check("async_rst_hit",  hit,  0);
    check("async_rst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    step(0, 8'h00, 0, 1, 8'h00, 0);
    check("post_rst_idle_valid", dvalid, 0);

`ifdef REG_BANK_SHADOW_EN
    step(1, 8'h10, 1, 0, 8'h7F, 0);
    check("sh_active_held", regs,    64'h0);
    check("sh_pending_set", pending, 1);
    step(0, 8'h00, 0, 0, 8'h00, 1);
    check("sh_commit_regs",    regs,    64'h7F);
    check("sh_commit_pending", pending, 0);
    step(1, 8'h10, 1, 0, 8'h01, 1);
    check("sh_cw_regs",    regs,    64'h7F);
    check("sh_cw_pending", pending, 1);
    step(0, 8'h00, 0, 0, 8'h00, 1);
    check("sh_cw_commit", regs, 64'h01);
`else
    step(1, 8'h10, 1, 0, 8'h7F, 1);
    check("nosh_commit_regs", regs,    64'h7F);
    check("nosh_pending2",    pending, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
